// File: rtl/mdu_pkg.sv
// Shared multiply/divide unit definitions: operand width default,
// mulctl encodings (func3[1:0]) and the multiply sequencer states.
package mdu_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        MUL_LO  = 2'b00,
        MUL_HSS = 2'b01,
        MUL_HSU = 2'b10,
        MUL_HUU = 2'b11
    } mulctl_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } mul_state_e;

    // rs1 is treated as signed for MULH and MULHSU
    function automatic logic rs1_is_signed(input mulctl_e ctl);
        return (ctl == MUL_HSS) || (ctl == MUL_HSU);
    endfunction

    // rs2 is treated as signed for MULH only
    function automatic logic rs2_is_signed(input mulctl_e ctl);
        return (ctl == MUL_HSS);
    endfunction

endpackage

// File: rtl/mul_unit_if.sv
// Request/response bundle between the core controller (master) and
// the iterative multiply unit (slave).
interface mul_unit_if
    import mdu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
);
    logic            mulstart;
    logic [1:0]      mulctl;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] result;
    logic            exdone;
    logic            busy;

    modport master (
        output mulstart, mulctl, rs1, rs2,
        input  result, exdone, busy
    );

    modport slave (
        input  mulstart, mulctl, rs1, rs2,
        output result, exdone, busy
    );
endinterface

// File: rtl/mul_unit_twos_neg.sv
// Conditional two's-complement negator: passes the input through when
// neg is low, returns its two's complement when neg is high.
module twos_neg #(
    parameter int W = 32
) (
    input  logic         neg,
    input  logic [W-1:0] a,
    output logic [W-1:0] y
);

    // Negate as invert-plus-one; the most negative value maps to itself,
    // which read as unsigned is exactly its magnitude.
    always_comb begin
        y = neg ? (~a + W'(1)) : a;
    end

endmodule

// File: rtl/mul_unit.sv
// Iterative shift-add multiplier for MUL/MULH/MULHSU/MULHU. Operands are
// converted to magnitudes on accept, multiplied unsigned over XLEN
// cycles, then the product sign is applied in a single fix-up cycle.
// Latency is fixed at XLEN+1 cycles from the accept edge.
module mul_unit
    import mdu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic      clk,
    input  logic      rst,
    mul_unit_if.slave bus
);

    localparam int CW = $clog2(XLEN + 1);

    mul_state_e        state_q, state_d;
    mulctl_e           ctl_q, ctl_d;
    logic              sign_q, sign_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              exdone_q, exdone_d;
    logic              busy_q, busy_d;

    mulctl_e           req_ctl;
    logic              rs1_neg;
    logic              rs2_neg;
    logic [XLEN-1:0]   rs1_mag;
    logic [XLEN-1:0]   rs2_mag;
    logic [XLEN:0]     addend;
    logic [XLEN:0]     step_sum;
    logic [2*XLEN-1:0] prod_fixed;

    // Decode the incoming request's operand signedness.
    always_comb begin
        req_ctl = mulctl_e'(bus.mulctl);
        rs1_neg = rs1_is_signed(req_ctl) & bus.rs1[XLEN-1];
        rs2_neg = rs2_is_signed(req_ctl) & bus.rs2[XLEN-1];
    end

    twos_neg #(.W(XLEN)) u_rs1_mag (
        .neg (rs1_neg),
        .a   (bus.rs1),
        .y   (rs1_mag)
    );

    twos_neg #(.W(XLEN)) u_rs2_mag (
        .neg (rs2_neg),
        .a   (bus.rs2),
        .y   (rs2_mag)
    );

    twos_neg #(.W(2*XLEN)) u_prod_fix (
        .neg (sign_q),
        .a   (acc_q),
        .y   (prod_fixed)
    );

    // One shift-add step: XLEN+1 bit adder keeps the carry, which is
    // shifted down into the top of the accumulator.
    always_comb begin
        addend   = acc_q[0] ? {1'b0, mcand_q} : '0;
        step_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + addend;
    end

    // Sequencer next-state: accept, iterate, sign fix-up, hold until the
    // request drops; dropping the request mid-operation aborts silently.
    always_comb begin
        state_d  = state_q;
        ctl_d    = ctl_q;
        sign_d   = sign_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.mulstart) begin
                    ctl_d   = req_ctl;
                    sign_d  = rs1_neg ^ rs2_neg;
                    mcand_d = rs1_mag;
                    acc_d   = {{XLEN{1'b0}}, rs2_mag};
                    cnt_d   = CW'(XLEN);
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                if (!bus.mulstart) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = {step_sum, acc_q[XLEN-1:1]};
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = ST_FIX;
                    end
                end
            end
            ST_FIX: begin
                if (!bus.mulstart) begin
                    state_d = ST_IDLE;
                end else begin
                    result_d = (ctl_q == MUL_LO) ? prod_fixed[XLEN-1:0]
                                                 : prod_fixed[2*XLEN-1:XLEN];
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!bus.mulstart) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        exdone_d = (state_d == ST_DONE);
        busy_d   = (state_d == ST_CALC) || (state_d == ST_FIX);
    end

    // State and registered outputs; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ctl_q    <= MUL_LO;
            sign_q   <= 1'b0;
            mcand_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            exdone_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctl_q    <= ctl_d;
            sign_q   <= sign_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            exdone_q <= exdone_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.result = result_q;
    assign bus.exdone = exdone_q;
    assign bus.busy   = busy_q;

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: directed RV32M cases, handshake hold,
// abort and reset checks, then randomized operations against a 64-bit
// arithmetic reference.
module tb_mul_unit;
    import mdu_pkg::*;

    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst;
    int   compared   = 0;
    int   mismatched = 0;
    logic [31:0] lastResult = '0;

    mul_unit_if #(.XLEN(XLEN)) bus ();

    mul_unit #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    // Global watchdog so a stuck design cannot hang the run
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference: sign- or zero-extend to 64 bits and multiply
    function automatic logic [31:0] refMul(input logic [1:0] ctl,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        ea = ((ctl == 2'b01 || ctl == 2'b10) && a[31]) ? {32'hFFFFFFFF, a} : {32'h0, a};
        eb = ((ctl == 2'b01) && b[31]) ? {32'hFFFFFFFF, b} : {32'h0, b};
        p  = ea * eb;
        return (ctl == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 5))
            0: return 32'h00000000;
            1: return 32'h00000001;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] ctl, input logic [31:0] a,
                                 input logic [31:0] b);
        bus.mulctl   = ctl;
        bus.rs1      = a;
        bus.rs2      = b;
        bus.mulstart = 1'b1;
    endtask

    // Issue one request, wait for exdone and check latency, busy span and result
    task automatic runOp(input string tag, input logic [1:0] ctl,
                         input logic [31:0] a, input logic [31:0] b);
        int n;
        int busyCnt;
        logic [31:0] expected;
        expected = refMul(ctl, a, b);
        applyStimulus(ctl, a, b);
        tick();
        n       = 0;
        busyCnt = bus.busy ? 1 : 0;
        while (!bus.exdone && n < 100) begin
            tick();
            n++;
            if (bus.busy) busyCnt++;
        end
        checkOutput($sformatf("%s_latency", tag), n, 33);
        checkOutput($sformatf("%s_busy_cycles", tag), busyCnt, 33);
        checkOutput($sformatf("%s_result", tag), bus.result, expected);
        lastResult = expected;
    endtask

    task automatic dropRequest(input string tag);
        bus.mulstart = 1'b0;
        tick();
        checkOutput($sformatf("%s_exdone_fall", tag), {31'b0, bus.exdone}, 32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        bus.mulstart = 1'b0;
        bus.mulctl   = 2'b00;
        bus.rs1      = '0;
        bus.rs2      = '0;
        tick();
        checkOutput("reset_result", bus.result, 32'd0);
        checkOutput("reset_exdone", {31'b0, bus.exdone}, 32'd0);
        checkOutput("reset_busy", {31'b0, bus.busy}, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Directed RV32M cases
        runOp("mul_7x6", MUL_LO, 32'd7, 32'd6);
        checkOutput("mul_7x6_const", bus.result, 32'h0000002A);
        dropRequest("mul_7x6");
        runOp("mulh_min_min", MUL_HSS, 32'h80000000, 32'h80000000);
        checkOutput("mulh_min_min_const", bus.result, 32'h40000000);
        dropRequest("mulh_min_min");
        runOp("mul_min_min", MUL_LO, 32'h80000000, 32'h80000000);
        dropRequest("mul_min_min");
        runOp("mulhsu_m1", MUL_HSU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        checkOutput("mulhsu_m1_const", bus.result, 32'hFFFFFFFF);
        dropRequest("mulhsu_m1");
        runOp("mulhu_max", MUL_HUU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        checkOutput("mulhu_max_const", bus.result, 32'hFFFFFFFE);
        dropRequest("mulhu_max");
        runOp("mulh_m2x3", MUL_HSS, 32'hFFFFFFFE, 32'd3);
        dropRequest("mulh_m2x3");
        runOp("mul_m2x3", MUL_LO, 32'hFFFFFFFE, 32'd3);
        checkOutput("mul_m2x3_const", bus.result, 32'hFFFFFFFA);
        dropRequest("mul_m2x3");

        // Hold the request past exdone while operands wander
        runOp("hold", MUL_HSS, 32'h12345678, 32'hFEDCBA98);
        for (int i = 0; i < 10; i++) begin
            bus.rs1    = $urandom;
            bus.rs2    = $urandom;
            bus.mulctl = 2'($urandom_range(0, 3));
            tick();
            checkOutput($sformatf("hold_exdone_%0d", i), {31'b0, bus.exdone}, 32'd1);
            checkOutput($sformatf("hold_result_%0d", i), bus.result, lastResult);
        end
        dropRequest("hold");
        runOp("hold_next", MUL_HUU, 32'hDEADBEEF, 32'h0000FFFF);
        dropRequest("hold_next");

        // Abort at CALC step 5
        applyStimulus(MUL_LO, 32'h00001111, 32'h00002222);
        tick();
        repeat (5) tick();
        bus.mulstart = 1'b0;
        tick();
        checkOutput("abort_busy", {31'b0, bus.busy}, 32'd0);
        repeat (40) tick();
        checkOutput("abort_exdone", {31'b0, bus.exdone}, 32'd0);
        checkOutput("abort_result", bus.result, lastResult);

        // Reset asserted at CALC step 20
        applyStimulus(MUL_HSU, 32'hCAFEF00D, 32'h87654321);
        tick();
        repeat (20) tick();
        rst = 1'b1;
        #1;
        checkOutput("midreset_result", bus.result, 32'd0);
        checkOutput("midreset_exdone", {31'b0, bus.exdone}, 32'd0);
        checkOutput("midreset_busy", {31'b0, bus.busy}, 32'd0);
        bus.mulstart = 1'b0;
        tick();
        rst = 1'b0;
        lastResult = '0;
        runOp("post_reset", MUL_HSS, 32'hFFFF0001, 32'h00030005);
        dropRequest("post_reset");

        // Randomized operations
        for (int i = 0; i < 16; i++) begin
            logic [1:0]  ctl;
            logic [31:0] a;
            logic [31:0] b;
            ctl = 2'($urandom_range(0, 3));
            a   = pickOperand();
            b   = pickOperand();
            runOp($sformatf("rand_%0d", i), ctl, a, b);
            dropRequest($sformatf("rand_%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mul_unit.md
# mul_unit

Iterative multiply unit for the RV32M multiply group (MUL, MULH, MULHSU, MULHU), sitting in the EX stage beside the ALU. It is the responder to the core controller's multiply request: it accepts `mulstart`/`mulctl` plus the two register operands, computes over a fixed number of cycles, and returns the result with `exdone` for the controller's EX→WB transition. Its latency is fixed and independent of the operand values; there is no early termination.

## Interface
- `XLEN`, default 32: operand and result width.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `mulstart`  in  1  request level from the controller.
- `mulctl`  in  2  operation select, equal to func3[1:0]: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- `rs1`  in  XLEN  multiplicand; signed for MULH and MULHSU.
- `rs2`  in  XLEN  multiplier; signed for MULH only.
- `result`  out  XLEN  low half of the product for MUL, high half otherwise.
- `exdone`  out  1  result valid; held until the request drops.
- `busy`  out  1  high in the CALC and FIX states.

## Operation
States: IDLE, CALC, FIX, DONE.
- **IDLE**
  - When `mulstart` = 1 at a rising edge: capture `mulctl` and the operand magnitudes, and record the product sign.
    - Product sign = (rs1 signed & rs1[XLEN-1]) XOR (rs2 signed & rs2[XLEN-1]).
  - Clear the 2·XLEN accumulator, load the counter with XLEN, and go to CALC.
- **CALC**, one shift-add step per cycle:
  - If the multiplier LSB is 1, add the multiplicand magnitude into the accumulator upper half.
  - Shift the {accumulator, multiplier} pair right by one.
  - Decrement the counter; after XLEN steps go to FIX.
  - The adder is XLEN+1 bits wide so the carry is kept.
- **FIX**
  - Negate the 2·XLEN product (two's complement) if the sign flag is set.
  - Register the low or high half into `result` according to the captured `mulctl`.
  - Go to DONE.
- **DONE**
  - `exdone` = 1 and `result` is stable.
  - Stay in DONE while `mulstart` = 1; go to IDLE when `mulstart` = 0.
- **Handshake**: 4-phase.
  - The requester must drop `mulstart` after sampling `exdone` and before the next multiply request.
  - Back-to-back multiplies therefore need at least one cycle with `mulstart` low.
- **Abort**: `mulstart` = 0 during CALC or FIX returns the unit to IDLE. `result` keeps its previous value and `exdone` is not asserted.
- **Operand changes**: `mulctl`, `rs1` and `rs2` are ignored outside the IDLE accept edge.
- **Magnitude of the most negative value**: |−2^(XLEN−1)| = 2^(XLEN−1) is representable as an unsigned XLEN-bit magnitude; no special case is needed.

## Timing
- **Reset values**: state = IDLE, `result` = 0, `exdone` = 0, `busy` = 0, counter = 0, accumulator = 0.
- **Latency**: the request is accepted at edge 0 and `exdone` rises after edge XLEN+1 (33 cycles for XLEN = 32).
- `busy` rises after edge 0 and falls after edge XLEN+1.
- **`exdone` fall**: one edge after `mulstart` is sampled low in DONE.
- **Reset asserted mid-operation**: outputs and state go to their reset values immediately (asynchronous), with no partial result. Operation resumes at the first edge after `rst` falls, if `mulstart` is high.
- All outputs are registered; there is no combinational path from any input to any output.

## Structure
- Shared package `mdu_pkg` holds:
  - the `mulctl` encodings (MUL_LO, MUL_HSS, MUL_HSU, MUL_HUU);
  - the state encoding;
  - the XLEN default.
- The controller's EX-stage decoder uses the same `mulctl` constants.
- One sub-module is natural: `twos_neg`, a parameterised-width conditional two's-complement negator. It is used for the operand magnitudes and the final product fix-up.

## Test plan
- MUL, rs1 = 7, rs2 = 6 → `exdone` rises 33 cycles after accept; `result` = 0x0000002A. `busy` is high for exactly 33 cycles.
- MULH, rs1 = rs2 = 0x80000000 → `result` = 0x40000000. MUL with the same operands → 0x00000000.
- MULHSU, rs1 = 0xFFFFFFFF (−1), rs2 = 0xFFFFFFFF (unsigned) → `result` = 0xFFFFFFFF. MULHU with the same operands → 0xFFFFFFFE.
- MULH, rs1 = 0xFFFFFFFE (−2), rs2 = 3 → `result` = 0xFFFFFFFF. MUL with the same operands → 0xFFFFFFFA.
- Hold `mulstart` high 10 cycles past `exdone` with the operands changing → `exdone` and `result` stay stable. Drop `mulstart` → `exdone` low next cycle. Re-assert `mulstart` → new result after 33 cycles.
- Two abort/reset checks:
  - Drop `mulstart` at CALC step 5 → IDLE, no `exdone`, `result` unchanged.
  - Assert `rst` at step 20 → all outputs 0 immediately; a fresh request after reset completes correctly.
